// File: rtl/bsg_print_stat_fifo_pkg.sv
// Shared types for the print-stat timestamp FIFO: entry layout and occupancy states.
package bsg_print_stat_fifo_pkg;

  localparam int tag_width_lp = 32;
  localparam int ts_width_lp  = 64;

  typedef struct packed {
    logic [tag_width_lp-1:0] tag;
    logic [ts_width_lp-1:0]  timestamp;
  } print_stat_entry_s;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occupancy_state_e;

endpackage

// File: rtl/bsg_print_stat_ring.sv
// Ring-buffer storage for print-stat entries: register array, write/read pointers
// wrapping modulo els_p (els_p must be a power of two).
module bsg_print_stat_ring
  import bsg_print_stat_fifo_pkg::*;
#(
  parameter int width_p = tag_width_lp + ts_width_lp,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               w_v_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] r_data_o
);

  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;

  // Power-of-two depth lets the pointer increment wrap on its own.
  always_comb begin
    wptr_d = wptr_q + ptr_w_lp'(w_v_i);
    rptr_d = rptr_q + ptr_w_lp'(yumi_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_q[wptr_q] <= w_data_i;
  end

  assign r_data_o = mem_q[rptr_q];

endmodule

// File: rtl/bsg_print_stat_timestamp_fifo.sv
// Captures print-stat events with the global cycle count into a ring buffer and
// counts drops on overflow. Optional macro BSG_PRINT_STAT_DELTA_EN stores deltas.
module bsg_print_stat_timestamp_fifo
  import bsg_print_stat_fifo_pkg::*;
#(
  parameter int data_width_p     = 32,
  parameter int ctr_width_p      = 64,
  parameter int els_p            = 8,
  parameter int drop_ctr_width_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         print_stat_v_i,
  input  logic [data_width_p-1:0]      print_stat_tag_i,
  input  logic [ctr_width_p-1:0]       global_ctr_i,
  output logic                         v_o,
  output logic [data_width_p-1:0]      tag_o,
  output logic [ctr_width_p-1:0]       timestamp_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o,
  output logic [drop_ctr_width_p-1:0]  drop_count_o,
  output logic                         overflow_o,
  input  logic                         drop_clear_i
);

  localparam int cnt_w_lp   = $clog2(els_p+1);
  localparam int entry_w_lp = data_width_p + ctr_width_p;
  localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els_p);

  occupancy_state_e             state_q, state_d;
  logic [cnt_w_lp-1:0]          count_q, count_d;
  logic                         v_q, v_d;
  logic [drop_ctr_width_p-1:0]  drop_q, drop_d, drop_base;
  logic                         ovf_q, ovf_d;
  logic                         space, enq, deq, drop;
  logic [ctr_width_p-1:0]       stored_ts;
  logic [entry_w_lp-1:0]        w_data, r_data;

  assign deq   = yumi_i & v_q;
  assign space = (state_q != FULL) | deq;
  assign enq   = print_stat_v_i & space;
  assign drop  = print_stat_v_i & ~space;

`ifdef BSG_PRINT_STAT_DELTA_EN
  logic [ctr_width_p-1:0] last_ts_q, last_ts_d;

  always_comb begin
    last_ts_d = enq ? global_ctr_i : last_ts_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) last_ts_q <= '0;
    else            last_ts_q <= last_ts_d;
  end

  assign stored_ts = global_ctr_i - last_ts_q;
`else
  assign stored_ts = global_ctr_i;
`endif

  always_comb begin
    count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (enq) state_d = PARTIAL;
      PARTIAL: begin
        if (enq && !deq && count_q == els_lp - 1'b1) state_d = FULL;
        else if (deq && !enq && count_q == cnt_w_lp'(1)) state_d = EMPTY;
      end
      FULL:    if (deq && !enq) state_d = PARTIAL;
      default: state_d = EMPTY;
    endcase
    v_d = (state_d != EMPTY);
  end

  // Clear takes effect before a same-cycle drop is counted.
  always_comb begin
    drop_base = drop_clear_i ? '0 : drop_q;
    drop_d    = drop_base;
    if (drop && !(&drop_base)) drop_d = drop_base + drop_ctr_width_p'(1);
    ovf_d = (drop_clear_i ? 1'b0 : ovf_q) | drop;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= EMPTY;
      count_q <= '0;
      v_q     <= 1'b0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      v_q     <= v_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign w_data = {print_stat_tag_i, stored_ts};

  bsg_print_stat_ring #(
    .width_p(entry_w_lp),
    .els_p  (els_p)
  ) ring (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .w_v_i    (enq),
    .w_data_i (w_data),
    .yumi_i   (deq),
    .r_data_o (r_data)
  );

  assign v_o          = v_q;
  assign tag_o        = r_data[entry_w_lp-1:ctr_width_p];
  assign timestamp_o  = r_data[ctr_width_p-1:0];
  assign count_o      = count_q;
  assign drop_count_o = drop_q;
  assign overflow_o   = ovf_q;

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_q);

endmodule
